// File: rtl/lfsr_multi_rng.sv
// rtl/lfsr_multi_rng.sv - multi-channel XNOR LFSR random generator with shared entropy seeding
// Each channel loads its seed from a shared free-running counter, advances STEPS shifts per fetch and repairs the all-ones lock-up state.
module lfsr_multi_rng #(
  parameter int               WIDTH    = 28,
  parameter logic [WIDTH-1:0] TAP_MASK = 28'h9000000,
  parameter int               NUM_CH   = 2,
  parameter int               STEPS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       fetch,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*WIDTH-1:0] rand_out,
  output logic [NUM_CH-1:0]       lockup
);

  logic [WIDTH-1:0] counter;

  // The counter keeps running through seeding, so a long start keeps tracking it.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else begin
      counter <= counter + WIDTH'(1);
    end
  end

  function automatic logic [WIDTH-1:0] step_n(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int k = 0; k < STEPS; k++) begin
      t = {t[WIDTH-2:0], ~^(t & TAP_MASK)};
    end
    return t;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] adv;
    logic             ack_q;
    logic             lock_q;

    assign seed = counter + WIDTH'(i);
    assign adv  = step_n(state);

    // All-ones is the XNOR lock-up state; it is never stored.
    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= '0;
        ack_q  <= 1'b0;
        lock_q <= 1'b0;
      end else if (start) begin
        state <= (&seed) ? '0 : seed;
        ack_q <= 1'b0;
      end else if (fetch[i]) begin
        ack_q <= 1'b1;
        if (&adv) begin
          state  <= '0;
          lock_q <= 1'b1;
        end else begin
          state <= adv;
        end
      end else begin
        ack_q <= 1'b0;
      end
    end

    assign rand_out[i*WIDTH +: WIDTH] = state;
    assign ack[i]    = ack_q;
    assign lockup[i] = lock_q;
  end

endmodule

// File: tb/tb_lfsr_multi_rng.sv
// tb/tb_lfsr_multi_rng.sv - directed vector bench for lfsr_multi_rng over four parameter sets
module tb_lfsr_multi_rng;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a, start_b, start_c, start_d;
  logic [1:0]  fetch_a, fetch_b;
  logic [0:0]  fetch_c, fetch_d;
  logic [1:0]  ack_a, ack_b, lock_a, lock_b;
  logic [0:0]  ack_c, ack_d, lock_c, lock_d;
  logic [55:0] rand_a;
  logic [7:0]  rand_b;
  logic [3:0]  rand_c, rand_d;

  lfsr_multi_rng dut_a (
    .clk(clk), .reset(reset), .start(start_a), .fetch(fetch_a),
    .ack(ack_a), .rand_out(rand_a), .lockup(lock_a)
  );

  lfsr_multi_rng #(.WIDTH(4), .TAP_MASK(4'h9), .NUM_CH(2), .STEPS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .fetch(fetch_b),
    .ack(ack_b), .rand_out(rand_b), .lockup(lock_b)
  );

  lfsr_multi_rng #(.WIDTH(4), .TAP_MASK(4'h0), .NUM_CH(1), .STEPS(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .fetch(fetch_c),
    .ack(ack_c), .rand_out(rand_c), .lockup(lock_c)
  );

  lfsr_multi_rng #(.WIDTH(4), .TAP_MASK(4'h1), .NUM_CH(1), .STEPS(3)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .fetch(fetch_d),
    .ack(ack_d), .rand_out(rand_d), .lockup(lock_d)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        start;
    logic [1:0]  fetch;
    logic [27:0] e0;
    logic [27:0] e1;
    logic [1:0]  eack;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Counter value seen at each edge equals the vector index (reset just before).
    tbl[0]  = '{1'b0, 2'b01, 28'h0000001, 28'h0000000, 2'b01};
    tbl[1]  = '{1'b0, 2'b01, 28'h0000003, 28'h0000000, 2'b01};
    tbl[2]  = '{1'b0, 2'b01, 28'h0000007, 28'h0000000, 2'b01};
    tbl[3]  = '{1'b0, 2'b01, 28'h000000F, 28'h0000000, 2'b01};
    tbl[4]  = '{1'b0, 2'b00, 28'h000000F, 28'h0000000, 2'b00};
    tbl[5]  = '{1'b1, 2'b00, 28'h0000005, 28'h0000006, 2'b00};
    tbl[6]  = '{1'b0, 2'b00, 28'h0000005, 28'h0000006, 2'b00};
    tbl[7]  = '{1'b1, 2'b00, 28'h0000007, 28'h0000008, 2'b00};
    tbl[8]  = '{1'b0, 2'b00, 28'h0000007, 28'h0000008, 2'b00};
    tbl[9]  = '{1'b1, 2'b11, 28'h0000009, 28'h000000A, 2'b00};
    tbl[10] = '{1'b0, 2'b11, 28'h0000013, 28'h0000015, 2'b11};
    tbl[11] = '{1'b0, 2'b10, 28'h0000013, 28'h000002B, 2'b10};
    tbl[12] = '{1'b0, 2'b00, 28'h0000013, 28'h000002B, 2'b00};

    start_a = 1'b1; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    fetch_a = 2'b11; fetch_b = 2'b00; fetch_c = 1'b0; fetch_d = 1'b0;
    reset = 1'b1;
    tick();
    chk("reset_rand_a", 64'(rand_a), 64'h0);
    chk("reset_ack_a", 64'(ack_a), 64'h0);
    chk("reset_lock_a", 64'(lock_a), 64'h0);
    chk("reset_rand_b", 64'(rand_b), 64'h0);

    reset = 1'b0;
    for (int v = 0; v < 13; v++) begin
      start_a = tbl[v].start;
      fetch_a = tbl[v].fetch;
      tick();
      chk($sformatf("v%0d_ch0", v), 64'(rand_a[27:0]), 64'(tbl[v].e0));
      chk($sformatf("v%0d_ch1", v), 64'(rand_a[55:28]), 64'(tbl[v].e1));
      chk($sformatf("v%0d_ack", v), 64'(ack_a), 64'(tbl[v].eack));
      chk($sformatf("v%0d_lock", v), 64'(lock_a), 64'h0);
    end
    start_a = 1'b0;
    fetch_a = 2'b00;

    // Lock-up seed substitution and counter wrap on the 4-bit instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    start_b = 1'b1;
    tick();
    chk("b_seed14", 64'(rand_b), 64'h0E);
    chk("b_seed14_lock", 64'(lock_b), 64'h0);
    tick();
    chk("b_seed15_wrap", 64'(rand_b), 64'h00);
    chk("b_seed15_lock", 64'(lock_b), 64'h0);
    start_b = 1'b0;
    fetch_b = 2'b11;
    tick();
    chk("b_fetch_rand", 64'(rand_b), 64'h11);
    chk("b_fetch_ack", 64'(ack_b), 64'h3);
    fetch_b = 2'b00;

    // Three steps per fetch with TAP_MASK 1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_d = 1'b1;
    tick();
    chk("d_step1", 64'(rand_d), 64'h5);
    chk("d_step1_ack", 64'(ack_d), 64'h1);
    tick();
    chk("d_step2", 64'(rand_d), 64'hA);
    chk("d_step2_lock", 64'(lock_d), 64'h0);
    fetch_d = 1'b0;
    tick();
    chk("d_idle_rand", 64'(rand_d), 64'hA);
    chk("d_idle_ack", 64'(ack_d), 64'h0);

    // Repair of all-ones result, sticky flag, then reset with fetch held.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_c = 1'b1;
    tick();
    chk("c_step1", 64'(rand_c), 64'h7);
    chk("c_step1_ack", 64'(ack_c), 64'h1);
    chk("c_step1_lock", 64'(lock_c), 64'h0);
    tick();
    chk("c_repair", 64'(rand_c), 64'h0);
    chk("c_repair_lock", 64'(lock_c), 64'h1);
    chk("c_repair_ack", 64'(ack_c), 64'h1);
    tick();
    chk("c_after_rand", 64'(rand_c), 64'h7);
    chk("c_after_lock", 64'(lock_c), 64'h1);
    reset = 1'b1;
    tick();
    chk("c_rst_rand", 64'(rand_c), 64'h0);
    chk("c_rst_ack", 64'(ack_c), 64'h0);
    chk("c_rst_lock", 64'(lock_c), 64'h0);
    reset = 1'b0;
    start_c = 1'b1;
    tick();
    chk("c_cnt0", 64'(rand_c), 64'h0);
    chk("c_cnt0_ack", 64'(ack_c), 64'h0);
    tick();
    chk("c_cnt1", 64'(rand_c), 64'h1);
    tick();
    chk("c_cnt2", 64'(rand_c), 64'h2);
    start_c = 1'b0;
    tick();
    chk("c_post_start", 64'(rand_c), 64'h7);
    chk("c_post_start_ack", 64'(ack_c), 64'h1);
    fetch_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
